// File: rtl/dmem_ctrl.sv
// Word-organised data memory behind a Req/Ready handshake with wait states, byte-lane stores and alignment checks.
// Define DMEM_LOADEXT_EN to return sign/zero-extended byte and half loads instead of the full aligned word.
module dmem_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int DEPTH    = 1024,
    parameter int WAIT_CYC = 2
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Req,
    output logic              Ready,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       WriteData,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic [1:0]        Size,
    input  logic              Unsigned,
    output logic [31:0]       ReadData,
    output logic              Valid,
    output logic              Misalign
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t             r_state, w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W+1:0]   r_addr;
    logic [31:0]        r_wdata;
    logic               r_we, r_re;
    logic [1:0]         r_size;
    logic               r_uns;
    logic [31:0]        r_rdata;
    logic               r_mis;
    logic [31:0]        r_mem [DEPTH];

    logic               w_accept, w_access, w_mis;
    logic [3:0]         w_be;
    logic [31:0]        w_wdat, w_word, w_load;
    logic [IDX_W-1:0]   w_idx;

`ifdef DMEM_LOADEXT_EN
    function automatic logic [31:0] f_load_ext(input logic [31:0] word, input logic [1:0] off,
                                               input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   return uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   return uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

    logic w_unused_addr;
    assign w_unused_addr = ^Address[ADDR_W-1:IDX_W+2];
    assign w_load = f_load_ext(w_word, r_addr[1:0], r_size, r_uns);
`else
    logic w_unused_in;
    assign w_unused_in = ^{Address[ADDR_W-1:IDX_W+2], Unsigned, r_uns};
    assign w_load = w_word;
`endif

    assign w_idx  = r_addr[IDX_W+1:2];
    assign w_word = r_mem[w_idx];
    assign w_mis  = (r_size == 2'b11) ||
                    (r_size == 2'b01 && r_addr[0]) ||
                    (r_size == 2'b10 && r_addr[1:0] != 2'b00);

    // FSM state register
    always_ff @(posedge Clk) begin
        if (Rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // FSM next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (Req) w_next = S_WAIT;
            S_WAIT:  if (r_cnt == '0) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        Ready    = (r_state == S_IDLE);
        Valid    = (r_state == S_RESP);
        w_accept = (r_state == S_IDLE) && Req;
        w_access = (r_state == S_WAIT) && (r_cnt == '0);
    end

    assign ReadData = r_rdata;
    assign Misalign = Valid && r_mis;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_cnt   <= '0;
            r_rdata <= '0;
            r_mis   <= 1'b0;
        end else begin
            if (w_accept)                  r_cnt <= CNT_W'(WAIT_CYC - 1);
            else if (r_state == S_WAIT && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            if (w_access) begin
                r_mis   <= w_mis;
                r_rdata <= (w_mis || r_we || !r_re) ? 32'd0 : w_load;
            end
        end
    end

    // Request fields only need to be valid at the acceptance edge
    always_ff @(posedge Clk) begin
        if (w_accept) begin
            r_addr  <= Address[IDX_W+1:0];
            r_wdata <= WriteData;
            r_we    <= MemWrite;
            r_re    <= MemRead;
            r_size  <= Size;
            r_uns   <= Unsigned;
        end
    end

    always_comb begin
        w_be   = 4'b0000;
        w_wdat = r_wdata;
        case (r_size)
            2'b00: begin
                w_be   = 4'b0001 << r_addr[1:0];
                w_wdat = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be   = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wdat = {2{r_wdata[15:0]}};
            end
            2'b10:   w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    // Reset at the access edge suppresses the store
    always_ff @(posedge Clk) begin
        if (!Rst && w_access && r_we && !w_mis) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdat[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl with default parameters (DEPTH=1024, WAIT_CYC=2).
module tb_dmem_ctrl;
    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Req = 1'b0;
    logic        Ready;
    logic [31:0] Address = '0;
    logic [31:0] WriteData = '0;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic [1:0]  Size = 2'b10;
    logic        Unsigned = 1'b0;
    logic [31:0] ReadData;
    logic        Valid;
    logic        Misalign;

    int n_cmp = 0;
    int n_err = 0;

    dmem_ctrl #(.ADDR_W(32), .DEPTH(1024), .WAIT_CYC(2)) dut (
        .Clk(Clk), .Rst(Rst), .Req(Req), .Ready(Ready), .Address(Address),
        .WriteData(WriteData), .MemWrite(MemWrite), .MemRead(MemRead), .Size(Size),
        .Unsigned(Unsigned), .ReadData(ReadData), .Valid(Valid), .Misalign(Misalign)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one request from IDLE; returns result and the number of edges from acceptance to Valid.
    task automatic xact(input logic [31:0] a, input logic [31:0] wd, input logic we, input logic re,
                        input logic [1:0] sz, input logic un,
                        output logic [31:0] rd, output logic mis, output int lat);
        Address = a; WriteData = wd; MemWrite = we; MemRead = re; Size = sz; Unsigned = un;
        Req = 1'b1;
        @(posedge Clk); #1;
        Req = 1'b0;
        lat = 0; rd = 32'hxxxxxxxx; mis = 1'bx;
        for (int i = 1; i <= 20; i++) begin
            @(posedge Clk); #1;
            if (Valid) begin
                lat = i; rd = ReadData; mis = Misalign;
                break;
            end
        end
        @(posedge Clk); #1;
    endtask

    logic [31:0] rd;
    logic        mis;
    int          lat;
    int          nvalid;

    initial begin
        // Reset
        Rst = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_ready", {31'd0, Ready}, 32'd1);
        chk("rst_valid", {31'd0, Valid}, 32'd0);
        chk("rst_misalign", {31'd0, Misalign}, 32'd0);
        chk("rst_readdata", ReadData, 32'd0);
        Rst = 1'b0;
        @(posedge Clk); #1;

        // Word store then load
        xact(32'h10, 32'hDEADBEEF, 1, 0, 2'b10, 0, rd, mis, lat);
        chk("st_word_lat", lat, 2);
        chk("st_word_mis", {31'd0, mis}, 0);
        xact(32'h10, 32'h0, 0, 1, 2'b10, 0, rd, mis, lat);
        chk("ld_word_lat", lat, 2);
        chk("ld_word_data", rd, 32'hDEADBEEF);
        chk("ld_word_mis", {31'd0, mis}, 0);
        chk("idle_valid_low", {31'd0, Valid}, 0);
        chk("idle_ready", {31'd0, Ready}, 1);

        // Byte and half stores merge into preserved lanes
        xact(32'h11, 32'h000000AA, 1, 0, 2'b00, 0, rd, mis, lat);
        chk("st_byte_mis", {31'd0, mis}, 0);
        xact(32'h10, 32'h0, 0, 1, 2'b10, 0, rd, mis, lat);
        chk("ld_after_byte", rd, 32'hDEADAAEF);
        xact(32'h12, 32'h00001234, 1, 0, 2'b01, 0, rd, mis, lat);
        chk("st_half_mis", {31'd0, mis}, 0);
        xact(32'h10, 32'h0, 0, 1, 2'b10, 0, rd, mis, lat);
        chk("ld_after_half", rd, 32'h1234AAEF);

        // Misaligned accesses
        xact(32'h13, 32'h0000FFFF, 1, 0, 2'b01, 0, rd, mis, lat);
        chk("mis_half_flag", {31'd0, mis}, 1);
        chk("mis_half_lat", lat, 2);
        xact(32'h10, 32'h0, 0, 1, 2'b10, 0, rd, mis, lat);
        chk("mis_half_nochange", rd, 32'h1234AAEF);
        xact(32'h10, 32'h0, 0, 1, 2'b11, 0, rd, mis, lat);
        chk("size11_flag", {31'd0, mis}, 1);
        chk("size11_data", rd, 32'd0);
        xact(32'h12, 32'h0, 0, 1, 2'b10, 0, rd, mis, lat);
        chk("mis_word_flag", {31'd0, mis}, 1);

        // Store+load together, and NOP
        xact(32'h30, 32'hCAFEF00D, 1, 1, 2'b10, 0, rd, mis, lat);
        chk("rw_data_zero", rd, 32'd0);
        xact(32'h30, 32'h0, 0, 1, 2'b10, 0, rd, mis, lat);
        chk("rw_store_done", rd, 32'hCAFEF00D);
        xact(32'h30, 32'h0, 0, 0, 2'b10, 0, rd, mis, lat);
        chk("nop_lat", lat, 2);
        chk("nop_data", rd, 32'd0);

        // Req held high through WAIT: only the first request is served
        Address = 32'h10; MemWrite = 0; MemRead = 1; Size = 2'b10; Req = 1'b1;
        @(posedge Clk); #1;
        chk("busy_ready_low", {31'd0, Ready}, 0);
        Address = 32'h30;
        nvalid = 0; rd = 32'hxxxxxxxx;
        for (int i = 0; i < 8; i++) begin
            @(posedge Clk); #1;
            if (Valid) begin
                nvalid++; rd = ReadData; Req = 1'b0;
            end
        end
        Req = 1'b0;
        chk("busy_one_valid", nvalid, 1);
        chk("busy_first_data", rd, 32'h1234AAEF);

        // Reset during WAIT aborts a pending store
        xact(32'h20, 32'h11111111, 1, 0, 2'b10, 0, rd, mis, lat);
        Address = 32'h20; WriteData = 32'h99999999; MemWrite = 1; MemRead = 0; Size = 2'b10;
        Req = 1'b1;
        @(posedge Clk); #1;
        Req = 1'b0; Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        chk("abort_ready", {31'd0, Ready}, 1);
        chk("abort_valid", {31'd0, Valid}, 0);
        xact(32'h20, 32'h0, 0, 1, 2'b10, 0, rd, mis, lat);
        chk("abort_no_store", rd, 32'h11111111);

        // Address aliasing modulo 4*DEPTH bytes
        xact(32'h1000, 32'h00000055, 1, 0, 2'b10, 0, rd, mis, lat);
        xact(32'h0000, 32'h0, 0, 1, 2'b10, 0, rd, mis, lat);
        chk("alias_data", rd, 32'h00000055);

        // Sub-word loads
`ifdef DMEM_LOADEXT_EN
        xact(32'h11, 32'h0, 0, 1, 2'b00, 0, rd, mis, lat);
        chk("ldb_signed", rd, 32'hFFFFFFAA);
        xact(32'h11, 32'h0, 0, 1, 2'b00, 1, rd, mis, lat);
        chk("ldb_unsigned", rd, 32'h000000AA);
        xact(32'h12, 32'h0, 0, 1, 2'b01, 0, rd, mis, lat);
        chk("ldh_signed", rd, 32'h00001234);
`else
        xact(32'h11, 32'h0, 0, 1, 2'b00, 0, rd, mis, lat);
        chk("ldb_fullword", rd, 32'h1234AAEF);
        xact(32'h12, 32'h0, 0, 1, 2'b01, 1, rd, mis, lat);
        chk("ldh_fullword", rd, 32'h1234AAEF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
